// File: rtl/mem_resp_pkg.sv
// -----------------------------------------------------------------------------
// mem_resp_pkg
// Shared definitions for the SRAM memory responder:
//   state_e    : responder FSM states (IDLE, LOW, HIGH, DONE)
//   SRAM_DW    : external SRAM data width (half of a 32-bit word)
//   CNT_W      : width of the per-phase wait counter (WAIT_CYCLES 0..15)
//   DEAD_BEEF  : value returned for reads that fall outside the SRAM
// -----------------------------------------------------------------------------
package mem_resp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam int          SRAM_DW   = 16;
  localparam int          CNT_W     = 4;
  localparam logic [31:0] DEAD_BEEF = 32'hDEAD_BEEF;

endpackage

// File: rtl/sram_phase_counter.sv
// -----------------------------------------------------------------------------
// sram_phase_counter
// Counts the cycles spent in one 16-bit SRAM phase and flags the last one.
// Ports:
//   clk_i      in   clock
//   rst_ni     in   asynchronous active-low reset
//   clear_i    in   force the count to 0 on the next edge (phase change / idle)
//   en_i       in   advance the count
//   tc_o       out  current cycle is the last cycle of the phase
//   tc_next_o  out  the next cycle will be the last cycle of the phase
// -----------------------------------------------------------------------------
module sram_phase_counter
  import mem_resp_pkg::*;
#(
  parameter int WAIT_CYCLES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic en_i,
  output logic tc_o,
  output logic tc_next_o
);

  localparam logic [CNT_W-1:0] TC = CNT_W'(WAIT_CYCLES);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_o      = (count_q == TC);
  // Lets the parent register strobes one cycle ahead of the count.
  assign tc_next_o = (count_d == TC);

endmodule

// File: rtl/sram_mem_responder.sv
// -----------------------------------------------------------------------------
// sram_mem_responder
// MEM-stage data-memory responder: executes one 32-bit read/write request as
// two 16-bit accesses (low half, then high half) on an asynchronous SRAM and
// holds ready low until the access completes.
//
// Optional feature macro: SRAM_RESP_RANGE_CHECK_EN
//   defined   : word addresses >= 2^(SRAM_AW-1) complete in one cycle without
//               touching the SRAM; reads return 32'hDEAD_BEEF.
//   undefined : out-of-range words alias by truncation.
//
// Ports:
//   clk          in   clock
//   rst          in   asynchronous active-low reset
//   rd_en        in   read request, held until ready
//   wr_en        in   write request, held until ready (wins over rd_en)
//   address      in   32-bit byte address, word aligned
//   write_data   in   32-bit store data
//   read_data    out  32-bit load data, valid with the ready that ends a read
//   ready        out  no request pending, or request completing this cycle
//   sram_addr    out  SRAM half-word address
//   sram_dq_out  out  SRAM write data
//   sram_dq_in   in   SRAM read data
//   sram_dq_oe   out  drive sram_dq_out onto the bus
//   sram_we_n    out  active-low SRAM write strobe
// -----------------------------------------------------------------------------
module sram_mem_responder
  import mem_resp_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'd1024,
  parameter int          WAIT_CYCLES = 2,
  parameter int          SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd_en,
  input  logic               wr_en,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [SRAM_DW-1:0] sram_dq_out,
  input  logic [SRAM_DW-1:0] sram_dq_in,
  output logic               sram_dq_oe,
  output logic               sram_we_n
);

  localparam int WW = SRAM_AW - 1;  // word index width

  state_e             state_q;
  logic               op_write_q;
  logic [WW-1:0]      word_q;
  logic [SRAM_DW-1:0] wdata_hi_q;
  logic [SRAM_DW-1:0] low_half_q;
  logic [31:0]        read_data_q;
  logic [SRAM_AW-1:0] sram_addr_q;
  logic [SRAM_DW-1:0] dq_out_q;
  logic               oe_q;
  logic               we_n_q;

  logic               req;
  logic [31:0]        byte_off;
  logic [WW-1:0]      word_idx;
  logic               out_of_range;
  logic               phase_active;
  logic               tc;
  logic               tc_next;
  logic               unused_bits;

  assign req      = rd_en | wr_en;
  assign byte_off = address - BASE_ADDR;
  assign word_idx = byte_off[WW+1:2];
  // Alignment bits are ignored; upper bits only matter to the range check.
  assign unused_bits = ^{byte_off[1:0], byte_off[31:WW+2]};

`ifdef SRAM_RESP_RANGE_CHECK_EN
  assign out_of_range = |byte_off[31:WW+2];
`else
  assign out_of_range = 1'b0;
`endif

  assign phase_active = (state_q == LOW) || (state_q == HIGH);

  sram_phase_counter #(
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_phase_counter (
    .clk_i     (clk),
    .rst_ni    (rst),
    .clear_i   (!phase_active || tc),
    .en_i      (phase_active),
    .tc_o      (tc),
    .tc_next_o (tc_next)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      op_write_q  <= 1'b0;
      word_q      <= '0;
      wdata_hi_q  <= '0;
      low_half_q  <= '0;
      read_data_q <= '0;
      sram_addr_q <= '0;
      dq_out_q    <= '0;
      oe_q        <= 1'b0;
      we_n_q      <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (req) begin
            op_write_q <= wr_en;
            word_q     <= word_idx;
            wdata_hi_q <= write_data[31:16];
            if (out_of_range) begin
              state_q <= DONE;
              if (!wr_en) begin
                read_data_q <= DEAD_BEEF;
              end
            end else begin
              state_q     <= LOW;
              sram_addr_q <= {word_idx, 1'b0};
              if (wr_en) begin
                dq_out_q <= write_data[15:0];
                oe_q     <= 1'b1;
                // Strobe released in the phase's last cycle for hold time.
                we_n_q   <= tc_next;
              end
            end
          end
        end
        LOW: begin
          if (tc) begin
            state_q     <= HIGH;
            sram_addr_q <= {word_q, 1'b1};
            if (op_write_q) begin
              dq_out_q <= wdata_hi_q;
              we_n_q   <= tc_next;
            end else begin
              low_half_q <= sram_dq_in;
            end
          end else if (op_write_q) begin
            we_n_q <= tc_next;
          end
        end
        HIGH: begin
          if (tc) begin
            state_q <= DONE;
            oe_q    <= 1'b0;
            we_n_q  <= 1'b1;
            // Both halves land together so read_data only changes on completion.
            if (!op_write_q) begin
              read_data_q <= {sram_dq_in, low_half_q};
            end
          end else if (op_write_q) begin
            we_n_q <= tc_next;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ready       = ((state_q == IDLE) && !req) || (state_q == DONE);
  assign read_data   = read_data_q;
  assign sram_addr   = sram_addr_q;
  assign sram_dq_out = dq_out_q;
  assign sram_dq_oe  = oe_q;
  assign sram_we_n   = we_n_q;

endmodule
